// File: rtl/queue_pkg.sv
// Shared helpers and channel width defaults for the parametrised message queue.
package queue_pkg;

  // Ceiling log2: the number of bits needed to index n distinct values.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer width. It is never below 1 bit, so DEPTH=1 still has a legal vector.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Message header: 2-bit opcode plus 2-bit param.
  localparam int HDR_OPCODE_W   = 2;
  localparam int HDR_PARAM_W    = 2;
  localparam int HDR_W          = HDR_OPCODE_W + HDR_PARAM_W;

  // Payload field widths used on the grant and release channels.
  localparam int GRANT_SINK_W   = 4;
  localparam int GRANT_DATA_W   = 64;
  localparam int RELEASE_ADDR_W = 32;
  localparam int RELEASE_DATA_W = 64;

endpackage

// File: rtl/queue_wrap_ctr.sv
// Increment-with-wrap counter used for the queue read and write pointers.
module queue_wrap_ctr #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Counts up on en and wraps from MAX to 0. clear has priority.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= (q == MAX_V) ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/param_queue.sv
// Parametrised decoupled queue with optional pipe/flow modes, occupancy count,
// almost-full flag and synchronous flush.
module param_queue
  import queue_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 2,
  parameter int PIPE         = 0,
  parameter int FLOW         = 0,
  parameter int AFULL_THRESH = DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        io_enq_valid,
  output logic                        io_enq_ready,
  input  logic [WIDTH-1:0]            io_enq_bits,
  output logic                        io_deq_valid,
  input  logic                        io_deq_ready,
  output logic [WIDTH-1:0]            io_deq_bits,
  output logic [clog2(DEPTH+1)-1:0]   io_count,
  output logic                        io_almost_full
);

  localparam int            CW      = clog2(DEPTH + 1);
  localparam int            PW      = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic          PIPE_EN = (PIPE != 0);
  localparam logic          FLOW_EN = (FLOW != 0);

  if (DEPTH < 1) begin : g_bad_depth
    $error("param_queue: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("param_queue: WIDTH must be >= 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("param_queue: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic             bypass;
  logic             stored_enq;
  logic             stored_deq;
  logic             ptr_clear;

  // Handshakes, bypass detection and the combinational read port.
  always_comb begin
    empty          = (count == '0);
    full           = (count == DEPTH_C);
    io_enq_ready   = !flush && (!full || (PIPE_EN && io_deq_ready));
    io_deq_valid   = !flush && (!empty || (FLOW_EN && io_enq_valid));
    do_enq         = io_enq_valid && io_enq_ready;
    do_deq         = io_deq_valid && io_deq_ready;
    // In a flow-through transfer the entry goes straight from enq to deq and never touches storage.
    bypass         = FLOW_EN && empty && do_enq && io_deq_ready;
    stored_enq     = do_enq && !bypass;
    stored_deq     = do_deq && !bypass;
    io_deq_bits    = (FLOW_EN && empty) ? io_enq_bits : mem[rd_ptr];
    io_almost_full = (count >= AFULL_C);
    io_count       = count;
    ptr_clear      = !reset || flush;
  end

  queue_wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_wr_ctr (
    .clk   (clk),
    .clear (ptr_clear),
    .en    (stored_enq),
    .q     (wr_ptr)
  );

  queue_wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_rd_ctr (
    .clk   (clk),
    .clear (ptr_clear),
    .en    (stored_deq),
    .q     (rd_ptr)
  );

  // Occupancy: reset and flush clear it; otherwise it tracks stored enq/deq.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(stored_enq) - CW'(stored_deq);
    end
  end

  // Storage has no reset. In pipe mode, a write to the slot being read is safe
  // because the read has already been taken combinationally.
  always_ff @(posedge clk) begin
    if (stored_enq) begin
      mem[wr_ptr] <= io_enq_bits;
    end
  end

  // Occupancy sanity checks for simulation: no overflow and no underflow.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      assert (count <= DEPTH_C);
      assert (!(stored_deq && empty));
      assert (!(stored_enq && full && !stored_deq));
    end
  end

endmodule

// File: tb/tb_param_queue.sv
// Scoreboard bench for param_queue: three instances cover the plain, pipe and
// flow/almost-full configurations.
module tb_param_queue;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      ev    = '0;
  logic [2:0]      dr    = '0;
  logic [2:0]      fl    = '0;
  logic [2:0][7:0] eb    = '0;
  wire  [2:0]      er;
  wire  [2:0]      dv;
  wire  [2:0]      af;
  wire  [2:0][7:0] db;
  wire  [1:0]      cnt_a;
  wire  [1:0]      cnt_b;
  wire  [2:0]      cnt_c;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];

  always #5 clk = ~clk;

  param_queue #(.WIDTH(8), .DEPTH(3), .PIPE(0), .FLOW(0), .AFULL_THRESH(3)) u_a (
    .clk(clk), .reset(reset), .flush(fl[0]),
    .io_enq_valid(ev[0]), .io_enq_ready(er[0]), .io_enq_bits(eb[0]),
    .io_deq_valid(dv[0]), .io_deq_ready(dr[0]), .io_deq_bits(db[0]),
    .io_count(cnt_a), .io_almost_full(af[0])
  );

  param_queue #(.WIDTH(8), .DEPTH(3), .PIPE(1), .FLOW(0), .AFULL_THRESH(3)) u_b (
    .clk(clk), .reset(reset), .flush(fl[1]),
    .io_enq_valid(ev[1]), .io_enq_ready(er[1]), .io_enq_bits(eb[1]),
    .io_deq_valid(dv[1]), .io_deq_ready(dr[1]), .io_deq_bits(db[1]),
    .io_count(cnt_b), .io_almost_full(af[1])
  );

  param_queue #(.WIDTH(8), .DEPTH(4), .PIPE(0), .FLOW(1), .AFULL_THRESH(2)) u_c (
    .clk(clk), .reset(reset), .flush(fl[2]),
    .io_enq_valid(ev[2]), .io_enq_ready(er[2]), .io_enq_bits(eb[2]),
    .io_deq_valid(dv[2]), .io_deq_ready(dr[2]), .io_deq_bits(db[2]),
    .io_count(cnt_c), .io_almost_full(af[2])
  );

  function automatic logic [31:0] cnt_of(input int q);
    case (q)
      0:       return {30'd0, cnt_a};
      1:       return {30'd0, cnt_b};
      default: return {29'd0, cnt_c};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int q, input logic [7:0] d);
    case (q)
      0:       sb0.push_back(d);
      1:       sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endtask

  task automatic mon_pop(input int q, input logic [7:0] got);
    logic [7:0] exp;
    int         sz;
    case (q)
      0:       sz = sb0.size();
      1:       sz = sb1.size();
      default: sz = sb2.size();
    endcase
    if (sz == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL deq%0d_unexpected: got %0h, expected no transfer", q, got);
    end else begin
      case (q)
        0:       exp = sb0.pop_front();
        1:       exp = sb1.pop_front();
        default: exp = sb2.pop_front();
      endcase
      chk($sformatf("deq%0d_bits", q), {24'd0, got}, {24'd0, exp});
    end
  endtask

  // Monitor: every accepted dequeue is compared against the scoreboard.
  always @(negedge clk) begin
    for (int q = 0; q < 3; q++) begin
      if (reset && dv[q] && dr[q]) mon_pop(q, db[q]);
    end
  end

  task automatic drive(input int q, input logic v, input logic [7:0] d,
                       input logic r, input logic f);
    ev[q] = v;
    eb[q] = d;
    dr[q] = r;
    fl[q] = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state on all instances.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int q = 0; q < 3; q++) begin
      chk($sformatf("rst%0d_count", q), cnt_of(q), 0);
      chk($sformatf("rst%0d_deq_valid", q), {31'd0, dv[q]}, 0);
      chk($sformatf("rst%0d_enq_ready", q), {31'd0, er[q]}, 1);
      chk($sformatf("rst%0d_afull", q), {31'd0, af[q]}, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Plain queue: fill, full behaviour, drain, wrapped refill.
    drive(0, 1, 8'h11, 0, 0); push(0, 8'h11);
    @(negedge clk);
    chk("a_empty_no_valid", {31'd0, dv[0]}, 0);
    chk("a_count0", cnt_of(0), 0);
    step();
    drive(0, 1, 8'h22, 0, 0); push(0, 8'h22);
    @(negedge clk);
    chk("a_count1", cnt_of(0), 1);
    chk("a_valid_after_1", {31'd0, dv[0]}, 1);
    step();
    drive(0, 1, 8'h33, 0, 0); push(0, 8'h33);
    @(negedge clk);
    chk("a_count2", cnt_of(0), 2);
    step();
    drive(0, 1, 8'h99, 1, 0);
    @(negedge clk);
    chk("a_count3", cnt_of(0), 3);
    chk("a_full_not_ready", {31'd0, er[0]}, 0);
    chk("a_afull_at3", {31'd0, af[0]}, 1);
    step();
    drive(0, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("a_drain_count2", cnt_of(0), 2);
    step();
    @(negedge clk);
    chk("a_drain_count1", cnt_of(0), 1);
    step();
    drive(0, 1, 8'h44, 0, 0); push(0, 8'h44);
    @(negedge clk);
    chk("a_drained_count", cnt_of(0), 0);
    chk("a_drained_valid", {31'd0, dv[0]}, 0);
    step();
    drive(0, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("a_refill_count", cnt_of(0), 1);
    step();
    drive(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("a_refill_drained", cnt_of(0), 0);
    step();

    // Flush at count 3 with an enqueue pending.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hA1 + 8'(i), 0, 0); push(0, 8'hA1 + 8'(i));
      step();
    end
    drive(0, 1, 8'hEE, 1, 1);
    @(negedge clk);
    chk("flush_enq_ready", {31'd0, er[0]}, 0);
    chk("flush_deq_valid", {31'd0, dv[0]}, 0);
    chk("flush_count_before", cnt_of(0), 3);
    step();
    sb0.delete();
    drive(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("flush_count_after", cnt_of(0), 0);
    chk("flush_afull_after", {31'd0, af[0]}, 0);
    chk("flush_valid_after", {31'd0, dv[0]}, 0);
    step();

    // Pipe mode: enqueue into a full queue while dequeuing.
    drive(1, 1, 8'h11, 0, 0); push(1, 8'h11); step();
    drive(1, 1, 8'h22, 0, 0); push(1, 8'h22); step();
    drive(1, 1, 8'h33, 0, 0); push(1, 8'h33); step();
    drive(1, 1, 8'h77, 0, 0);
    @(negedge clk);
    chk("b_full_count", cnt_of(1), 3);
    chk("b_full_no_deq_ready", {31'd0, er[1]}, 0);
    step();
    drive(1, 1, 8'h55, 1, 0); push(1, 8'h55);
    @(negedge clk);
    chk("b_pipe_enq_ready", {31'd0, er[1]}, 1);
    step();
    drive(1, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("b_pipe_count_held", cnt_of(1), 3);
    step();
    step();
    step();
    drive(1, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("b_drained_count", cnt_of(1), 0);
    chk("b_drained_valid", {31'd0, dv[1]}, 0);
    step();

    // Flow mode and almost-full threshold on the depth-4 instance.
    drive(2, 1, 8'hAB, 1, 0); push(2, 8'hAB);
    @(negedge clk);
    chk("c_flow_valid", {31'd0, dv[2]}, 1);
    chk("c_flow_count", cnt_of(2), 0);
    step();
    drive(2, 1, 8'hAB, 0, 0); push(2, 8'hAB);
    @(negedge clk);
    chk("c_bypass_not_stored", cnt_of(2), 0);
    chk("c_flow_valid_noready", {31'd0, dv[2]}, 1);
    step();
    drive(2, 1, 8'hC1, 0, 0); push(2, 8'hC1);
    @(negedge clk);
    chk("c_stored_count1", cnt_of(2), 1);
    chk("c_afull_at1", {31'd0, af[2]}, 0);
    step();
    drive(2, 1, 8'hC2, 1, 0); push(2, 8'hC2);
    @(negedge clk);
    chk("c_count2", cnt_of(2), 2);
    chk("c_afull_at2", {31'd0, af[2]}, 1);
    step();
    drive(2, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("c_enqdeq_count2", cnt_of(2), 2);
    chk("c_enqdeq_afull", {31'd0, af[2]}, 1);
    step();
    step();
    drive(2, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("c_drained_count", cnt_of(2), 0);
    chk("c_drained_afull", {31'd0, af[2]}, 0);
    step();

    // Reset mid-traffic at count 2.
    drive(0, 1, 8'h61, 0, 0); push(0, 8'h61); step();
    drive(0, 1, 8'h62, 0, 0); push(0, 8'h62); step();
    drive(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("r_count_before", cnt_of(0), 2);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    sb0.delete();
    @(negedge clk);
    chk("r_count_after", cnt_of(0), 0);
    chk("r_valid_after", {31'd0, dv[0]}, 0);
    chk("r_ready_after", {31'd0, er[0]}, 1);
    step();
    drive(0, 1, 8'h7E, 0, 0); push(0, 8'h7E); step();
    drive(0, 0, 8'h00, 1, 0);
    @(negedge clk);
    chk("r_post_count", cnt_of(0), 1);
    step();
    drive(0, 0, 8'h00, 0, 0);
    step();

    chk("sb0_left", sb0.size(), 0);
    chk("sb1_left", sb1.size(), 0);
    chk("sb2_left", sb2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/param_queue.md
Name: param_queue

Overview:
- Parametrised successor to the fixed 2-entry message queue used between the coherence hub and the AXI4 bridge.
- Depth and payload width are generic, and the payload is carried as one flat vector. The caller packs and unpacks header/payload fields.
- Adds pipe and flow modes, an explicit occupancy count, an almost-full flag and a synchronous flush.
- Drops in wherever the fixed queues sit today: TileLink grant/release/acquire channels and AXI response buffering.

Parameters:
- WIDTH, 64: payload bits per entry (>=1).
- DEPTH, 2: number of entries (>=1). Any integer is allowed, not only powers of two.
- PIPE, 0: 1 lets enq_ready stay high when full if deq_ready is high in the same cycle.
- FLOW, 0: 1 lets an enqueue pass combinationally to deq when the queue is empty.
- AFULL_THRESH, DEPTH: almost_full asserts when count >= AFULL_THRESH. Legal range is 1..DEPTH.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-low. 0 = reset, sampled on the clk rising edge.
- flush, in, 1: synchronous empty request.
- io_enq_valid, in, 1: producer has data.
- io_enq_ready, out, 1: queue accepts data.
- io_enq_bits, in, WIDTH: enqueue payload.
- io_deq_valid, out, 1: queue has data.
- io_deq_ready, in, 1: consumer accepts.
- io_deq_bits, out, WIDTH: dequeue payload.
- io_count, out, CW = clog2(DEPTH+1): current occupancy, 0..DEPTH.
- io_almost_full, out, 1: count >= AFULL_THRESH.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits, minimum 1 bit. Each increments and wraps from DEPTH-1 to 0. DEPTH=1 holds both at 0.
  - count register, CW bits.
  - empty = (count==0); full = (count==DEPTH).
- Reset (reset==0 at the edge): wr_ptr, rd_ptr and count go to 0. Storage is not reset.
- Outputs after reset: io_deq_valid=0, io_enq_ready=1, io_count=0, io_almost_full=0.
- Reset takes priority over flush and over both handshakes. Any in-flight data is discarded.
- Handshake rules:
  - io_enq_ready = !flush & (!full | (PIPE & io_deq_ready)).
  - io_deq_valid = !flush & (!empty | (FLOW & io_enq_valid)).
  - Valid/ready follow standard decoupled rules. A transfer occurs on any cycle where both are high.
- Write and pointer updates:
  - do_enq = enq_valid & enq_ready; do_deq = deq_valid & deq_ready.
  - FLOW bypass: when empty & FLOW & do_enq & io_deq_ready, nothing is written and no pointer or count changes.
  - Otherwise do_enq writes io_enq_bits to mem[wr_ptr] and advances wr_ptr.
  - do_deq (excluding the bypass case) advances rd_ptr.
- Data path:
  - io_deq_bits = (FLOW & empty) ? io_enq_bits : mem[rd_ptr]. The read is combinational.
  - Latency: 1 cycle from enqueue edge to deq_valid without FLOW, 0 cycles with FLOW.
- Count: count_next = count + stored_enq - stored_deq.
  - Simultaneous enq and deq leaves count unchanged with both pointers advancing.
  - Count never exceeds DEPTH and never underflows. An assertion checks this in simulation.
- Full, non-PIPE: enq_ready=0 even when deq_ready=1.
- Full, PIPE: a simultaneous enq and deq writes into the slot being freed. This is legal because the write lands at the edge and the read is combinational before it.
- Empty, non-FLOW: deq_valid=0 regardless of enq_valid.
- Flush:
  - While flush=1, both ready and valid are forced low, so no transfer can occur.
  - At the edge: wr_ptr, rd_ptr and count go to 0, and io_almost_full drops the next cycle.
- io_almost_full is a combinational compare on the count register.
- Parameter checks at elaboration: DEPTH>=1, WIDTH>=1, 1<=AFULL_THRESH<=DEPTH.

Decomposition:
- Package queue_pkg:
  - clog2 function.
  - ptr_width(DEPTH) helper returning max(1, clog2(DEPTH)).
  - Default constants for the message channel widths already in use: header 2+2, grant/release payload field widths.
- One sub-module, queue_wrap_ctr: an increment-with-wrap counter with parameter MAX, inputs en and clear (clear is reset or flush). It is instantiated twice, for wr_ptr and rd_ptr.
- Storage is an inline array in param_queue.

Test Plan:
- Fill/drain, DEPTH=3, WIDTH=8, no modes: enqueue 0x11, 0x22, 0x33 with deq_ready=0.
  - Required: count goes 1, 2, 3; enq_ready=0 once full.
  - Then deq_ready=1: outputs 0x11, 0x22, 0x33 in order. Count goes to 0, deq_valid falls.
  - Pointers wrap 2->0 correctly on refill with 0x44.
- PIPE=1, full at 3: enq 0x55 with deq_ready=1 in the same cycle.
  - Required: enq_ready=1, 0x11 is dequeued, count stays 3.
  - Entries then drain as 0x22, 0x33, 0x55.
- FLOW=1, empty: enq_valid=1 with 0xAB and deq_ready=1.
  - Required: deq_valid=1 and deq_bits=0xAB in the same cycle; count stays 0.
  - With deq_ready=0: 0xAB is stored, count=1.
- AFULL_THRESH=2, DEPTH=4: almost_full=0 at count 1 and 1 at count 2.
  - Simultaneous enq+deq at count 2 keeps it high.
- Flush at count 3 with enq_valid=1: enq_ready and deq_valid are 0 during the flush cycle.
  - Next cycle count=0 and almost_full=0; the enq data is not stored.
- Reset: drive reset=0 mid-traffic at count 2 for one cycle.
  - Next cycle count=0, deq_valid=0, enq_ready=1.
  - A subsequent enq of 0x7E dequeues as 0x7E.
